safe_lockout_ctrl: RTL and testbench
====================================

SAFE_LOCKOUT_CTRL -- requirements
Module: safe_lockout_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_FAILS, default 3 (range 1..3): consecutive wrong-code reports that trigger lockout.
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 500 (range 1..2^32-1): lockout duration in clk cycles.
REQ-003 The block SHALL have parameter RELOCK_CYCLES, default 1500: idle-open timeout in cycles, used only under REQ-025.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_raw  input  4  raw, unsynchronised buttons BTN[3:0].
REQ-007 fsm_fail  input  1  one-cycle pulse from the safe FSM on a wrong digit.
REQ-008 fsm_unlocked  input  1  safe FSM unlocked level.
REQ-009 btn_out  output  4  one-cycle press pulse to the safe FSM; 0000 otherwise.
REQ-010 locked_out  output  1  high while in LOCKOUT.
REQ-011 fail_cnt  output  2  consecutive-failure count.
REQ-012 force_relock  output  1  one-cycle request to the safe FSM to return to its initial state.

Function
REQ-013 btn_raw SHALL pass through a 2-flop synchroniser (s1, s2) plus a history flop s3.
REQ-014 A press is detected when s2 != 0 and s3 == 0; btn_out SHALL be registered as s2 on the next edge, giving 3-cycle latency from a btn_raw 0->nonzero change.
REQ-015 btn_out SHALL be high for exactly one cycle per press; a held button, or a change between two nonzero codes, SHALL NOT produce a further pulse.
REQ-016 FSM states are ARMED, LOCKOUT and OPEN; reset state is ARMED.
REQ-017 ARMED, fsm_fail=1, fail_cnt < MAX_FAILS-1: fail_cnt SHALL increment, state stays ARMED.
REQ-018 ARMED, fsm_fail=1, fail_cnt == MAX_FAILS-1: the block SHALL go to LOCKOUT, clear fail_cnt to 0, and load the 32-bit lock timer with LOCK_CYCLES-1.
REQ-019 LOCKOUT: the timer SHALL decrement each cycle; at timer==0 the block SHALL go to ARMED, so locked_out is high for exactly LOCK_CYCLES cycles.
REQ-020 LOCKOUT: btn_out SHALL be forced to 0000; presses detected during LOCKOUT SHALL be discarded, not queued; fsm_fail SHALL be ignored.
REQ-021 ARMED, fsm_unlocked=1: the block SHALL go to OPEN and clear fail_cnt; if fsm_fail is asserted in the same cycle, unlocked wins and the fail is ignored.
REQ-022 OPEN: fsm_fail SHALL be ignored; when fsm_unlocked=0 the block SHALL go to ARMED; btn_out passes normally.
REQ-023 A press pulse is held in the btn_out register; a state transition in the same cycle SHALL NOT drop it, except entry into LOCKOUT, which zeroes it.

Reset
REQ-024 While rst_n=0: state=ARMED, fail_cnt=0, timer=0, relock counter=0, s1/s2/s3=0, btn_out=0000, locked_out=0, force_relock=0; a mid-lockout reset aborts the lockout immediately.

Configuration
REQ-025 With macro SAFE_LOCKOUT_RELOCK_EN defined: in OPEN, a 32-bit idle counter SHALL count cycles with no press; each press clears it; reaching RELOCK_CYCLES-1 SHALL pulse force_relock for 1 cycle and clear the counter; leaving OPEN clears it.
REQ-026 Without SAFE_LOCKOUT_RELOCK_EN: force_relock SHALL be constant 0, no idle counter SHALL be instantiated, and RELOCK_CYCLES is unused.

Verification
All scenarios use MAX_FAILS=3 and LOCK_CYCLES=10.
REQ-027 Press: btn_raw 0000->0111 held 20 cycles -> btn_out=0111 for 1 cycle, exactly 3 cycles after the change, then 0000.
REQ-028 Lockout: three fsm_fail pulses in ARMED -> fail_cnt 1, then 2, then 0 with locked_out=1 for exactly 10 cycles; a press during that window -> btn_out stays 0000 and no pulse follows lockout exit.
REQ-029 Unlock: fail_cnt=2, then fsm_unlocked=1 and fsm_fail=1 in the same cycle -> state OPEN, fail_cnt=0, locked_out=0.
REQ-030 Reset mid-lockout: rst_n=0 at lockout cycle 4 -> locked_out=0 and fail_cnt=0 asynchronously; a press after release -> normal btn_out pulse.
REQ-031 With SAFE_LOCKOUT_RELOCK_EN and RELOCK_CYCLES=8: hold OPEN with no press -> force_relock 1-cycle pulse at idle cycle 8; a press at idle cycle 5 -> no pulse until 8 cycles after that press.
REQ-032 Without SAFE_LOCKOUT_RELOCK_EN: same stimulus as REQ-031 -> force_relock remains 0 throughout.

Source files
------------

// File: rtl/safe_lockout_ctrl.sv
// safe_lockout_ctrl
//   Button front-end and wrong-code lockout for a keypad safe. It synchronises the
//   raw buttons, turns each new press into a one-cycle pulse, and counts consecutive
//   wrong-code reports from the safe FSM. When the count reaches the limit it enters
//   LOCKOUT for a fixed number of cycles, and swallows presses and fails during it.
//
//   Optional feature: define SAFE_LOCKOUT_RELOCK_EN to add an idle timer while OPEN.
//   After RELOCK_CYCLES cycles without a press it pulses force_relock.
//
// Parameters
//   MAX_FAILS     consecutive wrong codes that trigger lockout (1..3)
//   LOCK_CYCLES   lockout duration in clk cycles (>= 1)
//   RELOCK_CYCLES idle-open timeout in cycles (used only with SAFE_LOCKOUT_RELOCK_EN)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   btn_raw[3:0]  raw, unsynchronised buttons
//   fsm_fail      one-cycle wrong-digit pulse from the safe FSM
//   fsm_unlocked  safe FSM unlocked level
//   btn_out[3:0]  one-cycle press pulse to the safe FSM, 0000 otherwise
//   locked_out    high while in LOCKOUT
//   fail_cnt[1:0] consecutive-failure count
//   force_relock  one-cycle request to the safe FSM to return to its initial state

module safe_lockout_ctrl #(
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned LOCK_CYCLES   = 500,
  parameter int unsigned RELOCK_CYCLES = 1500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       fsm_fail,
  input  logic       fsm_unlocked,
  output logic [3:0] btn_out,
  output logic       locked_out,
  output logic [1:0] fail_cnt,
  output logic       force_relock
);

  typedef enum logic [1:0] {
    StArmed   = 2'd0,
    StLockout = 2'd1,
    StOpen    = 2'd2
  } state_e;

  localparam logic [1:0]  LastFail  = 2'(MAX_FAILS - 1);
  localparam logic [31:0] LockLoad  = 32'(LOCK_CYCLES - 1);

  // Elaboration-time guard on the configuration.
  if (MAX_FAILS == 0 || MAX_FAILS > 3 || LOCK_CYCLES == 0 || RELOCK_CYCLES == 0) begin : g_bad_cfg
    $error("safe_lockout_ctrl: parameter out of range");
  end

  state_e      state_q;
  logic [3:0]  s1_q, s2_q, s3_q;
  logic [31:0] timer_q;
  logic        press;

  // New press: synchronised value is nonzero and the previous one was idle.
  // A change between two nonzero codes therefore never re-triggers.
  assign press = (s2_q != 4'b0000) && (s3_q == 4'b0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StArmed;
      s1_q       <= 4'b0000;
      s2_q       <= 4'b0000;
      s3_q       <= 4'b0000;
      timer_q    <= 32'd0;
      btn_out    <= 4'b0000;
      locked_out <= 1'b0;
      fail_cnt   <= 2'd0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      btn_out <= press ? s2_q : 4'b0000;

      unique case (state_q)
        StArmed: begin
          // Unlock takes priority over a simultaneous fail.
          if (fsm_unlocked) begin
            state_q  <= StOpen;
            fail_cnt <= 2'd0;
          end else if (fsm_fail) begin
            if (fail_cnt == LastFail) begin
              state_q    <= StLockout;
              locked_out <= 1'b1;
              fail_cnt   <= 2'd0;
              timer_q    <= LockLoad;
              btn_out    <= 4'b0000;
            end else begin
              fail_cnt <= fail_cnt + 2'd1;
            end
          end
        end
        StLockout: begin
          // Presses seen here are dropped, including on the exit cycle.
          btn_out <= 4'b0000;
          if (timer_q == 32'd0) begin
            state_q    <= StArmed;
            locked_out <= 1'b0;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        StOpen: begin
          if (!fsm_unlocked) begin
            state_q <= StArmed;
          end
        end
        default: begin
          state_q    <= StArmed;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAFE_LOCKOUT_RELOCK_EN
  localparam logic [31:0] IdleLast = 32'(RELOCK_CYCLES - 1);

  logic [31:0] idle_q;

  // Counts only while staying OPEN; any other cycle clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q       <= 32'd0;
      force_relock <= 1'b0;
    end else begin
      force_relock <= 1'b0;
      if (state_q == StOpen && fsm_unlocked) begin
        if (press) begin
          idle_q <= 32'd0;
        end else if (idle_q == IdleLast) begin
          idle_q       <= 32'd0;
          force_relock <= 1'b1;
        end else begin
          idle_q <= idle_q + 32'd1;
        end
      end else begin
        idle_q <= 32'd0;
      end
    end
  end
`else
  assign force_relock = 1'b0;
`endif

endmodule

// File: tb/tb_safe_lockout_ctrl.sv
// Self-checking bench for safe_lockout_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a cycle-count reference model.
module tb_safe_lockout_ctrl;

  localparam int MF = 3;
  localparam int LC = 10;
  localparam int RC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic       fsm_fail = 1'b0;
  logic       fsm_unlocked = 1'b0;
  logic [3:0] btn_out;
  logic       locked_out;
  logic [1:0] fail_cnt;
  logic       force_relock;

  int checks = 0;
  int errors = 0;

  safe_lockout_ctrl #(
    .MAX_FAILS    (MF),
    .LOCK_CYCLES  (LC),
    .RELOCK_CYCLES(RC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .fsm_fail    (fsm_fail),
    .fsm_unlocked(fsm_unlocked),
    .btn_out     (btn_out),
    .locked_out  (locked_out),
    .fail_cnt    (fail_cnt),
    .force_relock(force_relock)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] hist [3];   // raw samples, [0] newest
  int         fails_m;
  int         lock_left;  // remaining locked cycles, 0 = not locked
  bit         open_m;
  int         idle_m;
  logic [3:0] exp_btn;
  bit         exp_force;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = 4'b0000;
    fails_m = 0; lock_left = 0; open_m = 0; idle_m = 0;
    exp_btn = 4'b0000; exp_force = 0;
  endtask

  task automatic model_update();
    logic [3:0] s2v;
    bit press, was_locked, was_open, entering;
    s2v        = hist[1];
    press      = (hist[1] != 4'b0000) && (hist[2] == 4'b0000);
    was_locked = lock_left > 0;
    was_open   = open_m;
    entering   = 0;
    if (was_locked) lock_left--;
    else if (open_m) begin
      if (!fsm_unlocked) open_m = 0;
    end else if (fsm_unlocked) begin
      open_m = 1; fails_m = 0;
    end else if (fsm_fail) begin
      if (fails_m == MF - 1) begin
        lock_left = LC; fails_m = 0; entering = 1;
      end else fails_m++;
    end
    exp_btn = (press && !was_locked && !entering) ? s2v : 4'b0000;
    exp_force = 0;
`ifdef SAFE_LOCKOUT_RELOCK_EN
    if (was_open && fsm_unlocked) begin
      if (press) idle_m = 0;
      else begin
        idle_m++;
        if (idle_m == RC) begin exp_force = 1; idle_m = 0; end
      end
    end else idle_m = 0;
`else
    if (was_open) idle_m = 0;
`endif
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btn_raw;
  endtask

  task automatic compare_all();
    check("btn_out", 32'(btn_out), 32'(exp_btn));
    check("locked_out", 32'(locked_out), 32'(lock_left > 0));
    check("fail_cnt", 32'(fail_cnt), 32'(fails_m));
    check("force_relock", 32'(force_relock), 32'(exp_force));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse issued between clock edges.
  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < hold; i++) cycle();
    rst_n = 1'b1;
  endtask

  task automatic fail_pulse();
    fsm_fail = 1'b1;
    cycle();
    fsm_fail = 1'b0;
  endtask

  int pulses, pulse_at, lock_count, force_count, first_force;

  initial begin
    model_reset();
    // Reset state
    #1;
    compare_all();
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Press latency and single pulse on a held button
    btn_raw = 4'b0111;
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (btn_out != 4'b0000) begin pulses++; pulse_at = i; end
      if (i == 10) btn_raw = 4'b0011;  // nonzero-to-nonzero change
    end
    check("press_count", 32'(pulses), 32'd1);
    check("press_latency", 32'(pulse_at), 32'd3);
    btn_raw = 4'b0000;
    for (int i = 0; i < 4; i++) cycle();

    // Three fails -> lockout; press during lockout is discarded
    fail_pulse(); cycle();
    check("fail1", 32'(fail_cnt), 32'd1);
    fail_pulse(); cycle();
    check("fail2", 32'(fail_cnt), 32'd2);
    fail_pulse();
    check("fail3_clear", 32'(fail_cnt), 32'd0);
    lock_count = locked_out ? 1 : 0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) btn_raw = 4'b0001;
      if (i == 5) fsm_fail = 1'b1;
      if (i == 6) fsm_fail = 1'b0;
      cycle();
      if (locked_out) lock_count++;
      if (btn_out != 4'b0000) pulses++;
    end
    check("lock_len", 32'(lock_count), 32'(LC));
    check("lock_press_dropped", 32'(pulses), 32'd0);
    btn_raw = 4'b0000;
    for (int i = 0; i < 4; i++) cycle();

    // Unlock wins over a simultaneous fail
    fail_pulse(); fail_pulse();
    check("pre_unlock_cnt", 32'(fail_cnt), 32'd2);
    fsm_unlocked = 1'b1; fsm_fail = 1'b1;
    cycle();
    fsm_fail = 1'b0;
    check("unlock_cnt", 32'(fail_cnt), 32'd0);
    check("unlock_lock", 32'(locked_out), 32'd0);
    for (int i = 0; i < 3; i++) fail_pulse();  // ignored while open
    check("open_fail_ignored", 32'(locked_out), 32'd0);

    // Idle-open relock timing
    fsm_unlocked = 1'b0; cycle();
    fsm_unlocked = 1'b1; cycle();     // enters OPEN
    force_count = 0; first_force = -1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 12) btn_raw = 4'b1000;
      if (i == 16) btn_raw = 4'b0000;
      cycle();
      if (force_relock) begin
        force_count++;
        if (first_force < 0) first_force = i;
      end
    end
`ifdef SAFE_LOCKOUT_RELOCK_EN
    check("relock_first", 32'(first_force), 32'd8);
`else
    check("relock_none", 32'(force_count), 32'd0);
`endif
    fsm_unlocked = 1'b0; cycle(); cycle();

    // Reset in the middle of a lockout, then a normal press
    fail_pulse(); fail_pulse(); fail_pulse();
    for (int i = 0; i < 3; i++) cycle();
    check("lock_active", 32'(locked_out), 32'd1);
    async_reset(2);
    check("rst_lock_cleared", 32'(locked_out), 32'd0);
    cycle();
    btn_raw = 4'b0100;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (btn_out == 4'b0100) pulses++;
    end
    check("post_reset_press", 32'(pulses), 32'd1);
    btn_raw = 4'b0000;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0)
        btn_raw = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      fsm_fail = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) fsm_unlocked = ~fsm_unlocked;
      if ($urandom_range(0, 499) == 0) async_reset(1);
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
